// File: rtl/wm8731_pkg.sv
// rtl/wm8731_pkg.sv - shared types and constants for the WM8731 control-port responder
//
// Contents: responder FSM state type, codec register indices, the register
// image layout (11 slots: R0-R9 then R15) with its power-on values, and
// helpers that map a register index onto an image slot.
package wm8731_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_BYTE1,
        ST_ACK1,
        ST_BYTE2,
        ST_ACK2,
        ST_WAIT_STOP
    } state_t;

    localparam int         NUM_REG_SLOTS    = 11;
    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

    localparam logic [6:0] R_LLINE  = 7'd0;
    localparam logic [6:0] R_RLINE  = 7'd1;
    localparam logic [6:0] R_LHP    = 7'd2;
    localparam logic [6:0] R_RHP    = 7'd3;
    localparam logic [6:0] R_AAPATH = 7'd4;
    localparam logic [6:0] R_DAPATH = 7'd5;
    localparam logic [6:0] R_PWR    = 7'd6;
    localparam logic [6:0] R_IFACE  = 7'd7;
    localparam logic [6:0] R_SRATE  = 7'd8;
    localparam logic [6:0] R_ACTIVE = 7'd9;
    localparam logic [6:0] R_RESET  = 7'd15;

    localparam logic [8:0] REG_DEFAULTS [NUM_REG_SLOTS] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000,
        9'h000
    };

    // R0-R9 and R15 exist on the codec; everything else is rejected.
    function automatic logic reg_is_legal(input logic [6:0] idx);
        return (idx <= R_ACTIVE) || (idx == R_RESET);
    endfunction

    // R15 lives in the last slot; R0-R9 map one-to-one.
    function automatic logic [3:0] reg_slot(input logic [6:0] idx);
        return (idx == R_RESET) ? 4'd10 : idx[3:0];
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizer with bus-event detection
//
// Ports:
//   i_clk, i_rst       system clock, async active-high reset
//   i_scl, i_sda       raw bus lines (asynchronous to i_clk)
//   o_scl_rise         SCL rising edge (data sample point)
//   o_scl_fall         SCL falling edge (drive-change point)
//   o_start, o_stop    START / STOP conditions (SDA edge while SCL high)
//   o_sda_s            synchronized SDA level
// Events are combinational from the last sync stage and one history register,
// giving SYNC_STAGES+1 cycles from pin to the consuming register.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl_s;
    logic                   w_sda_s;

    // Reset to 1 (idle bus) so leaving reset never fakes an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
        end
    end

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign o_sda_s    = w_sda_s;
    assign o_scl_rise = w_scl_s & ~r_scl_d;
    assign o_scl_fall = ~w_scl_s & r_scl_d;
    // SCL must be high on both samples so an SDA change near an SCL edge
    // is not mistaken for a bus condition.
    assign o_start    = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
    assign o_stop     = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// rtl/wm8731_i2c_responder.sv - I2C target modelling the WM8731 codec control port
//
// Accepts 3-byte writes {addr+W, reg[6:0]|data[8], data[7:0]}, ACKs them and
// keeps the codec register image.
// Optional feature macro: WM8731_RESP_SOFTRESET_EN - when defined, a write to
// R15 restores R0-R9 to their defaults; otherwise R15 is stored like any register.
//
// Ports:
//   i_clk, i_rst   system clock (>= 8x SCL), async active-high reset
//   i_scl, i_sda   I2C bus lines as seen on the bus
//   o_sda_oe       1 = pull SDA low (ACK)
//   o_wr_valid     one-cycle pulse per committed legal write
//   o_wr_addr      register index of the last committed write
//   o_wr_data      data of the last committed write
//   o_regs         image, slot k = [9k+8:9k], slots 0-9 = R0-R9, slot 10 = R15
//   o_busy         high between START and STOP
//   o_err          one-cycle pulse on a write to an illegal register index
module wm8731_i2c_responder
    import wm8731_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_scl,
    input  logic        i_sda,
    output logic        o_sda_oe,
    output logic        o_wr_valid,
    output logic [6:0]  o_wr_addr,
    output logic [8:0]  o_wr_data,
    output logic [98:0] o_regs,
    output logic        o_busy,
    output logic        o_err
);

    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_sda_s;
    logic [7:0] w_byte;
    logic [8:0] w_wr_data;
    logic       w_last_bit;

    state_t     r_state;
    logic [6:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_reg_idx;
    logic       r_data8;
    logic       r_sda_oe;
    logic       r_wr_valid;
    logic       r_err;
    logic       r_busy;
    logic [6:0] r_wr_addr;
    logic [8:0] r_wr_data;
    logic [8:0] r_regs [NUM_REG_SLOTS];

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_sda_s    (w_sda_s)
    );

    // Byte as it stands including the bit sampled on this SCL rise.
    assign w_byte     = {r_shift, w_sda_s};
    assign w_wr_data  = {r_data8, w_byte};
    assign w_last_bit = (r_bit_cnt == 3'd7);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_reg_idx  <= '0;
            r_data8    <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int k = 0; k < NUM_REG_SLOTS; k++) begin
                r_regs[k] <= REG_DEFAULTS[k];
            end
        end else begin
            r_wr_valid <= 1'b0;
            r_err      <= 1'b0;
            if (w_stop) begin
                // Any write not yet committed is simply dropped.
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b1;
            end else begin
                case (r_state)
                    ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                if (r_state == ST_ADDR) begin
                                    // Only a write to our address is ACKed.
                                    r_state <= (w_byte == {DEV_ADDR, 1'b0})
                                               ? ST_ADDR_ACK : ST_WAIT_STOP;
                                end else if (r_state == ST_BYTE1) begin
                                    r_reg_idx <= w_byte[7:1];
                                    r_data8   <= w_byte[0];
                                    r_state   <= ST_ACK1;
                                end else begin
                                    // Commit point; BYTE2 is ACKed even if rejected.
                                    r_state <= ST_ACK2;
                                    if (reg_is_legal(r_reg_idx)) begin
`ifdef WM8731_RESP_SOFTRESET_EN
                                        if (r_reg_idx == R_RESET) begin
                                            for (int k = 0; k < NUM_REG_SLOTS - 1; k++) begin
                                                r_regs[k] <= REG_DEFAULTS[k];
                                            end
                                        end
`endif
                                        r_regs[reg_slot(r_reg_idx)] <= w_wr_data;
                                        r_wr_addr  <= r_reg_idx;
                                        r_wr_data  <= w_wr_data;
                                        r_wr_valid <= 1'b1;
                                    end else begin
                                        r_err <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
                        // First SCL fall grabs SDA, the next one releases it and
                        // hands over to the following byte.
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= '0;
                                case (r_state)
                                    ST_ADDR_ACK: r_state <= ST_BYTE1;
                                    ST_ACK1:     r_state <= ST_BYTE2;
                                    default:     r_state <= ST_WAIT_STOP;
                                endcase
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_sda_oe   = r_sda_oe;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = r_busy;
    assign o_err      = r_err;

    for (genvar g = 0; g < NUM_REG_SLOTS; g++) begin : g_regs
        assign o_regs[9*g +: 9] = r_regs[g];
    end

endmodule
